uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver for the board serial port. Takes the UART_RXD pad, which idles high, and delivers received bytes to the system bus side over a valid/ready handshake with a one-byte holding register.
- Receive-side counterpart of the UART transmitter that drives UART_TXD.
- Runs in the 24 MHz system clock domain, uses 16x oversampling and centre-of-bit sampling, and reports framing and overrun errors.

Parameters:
- CLK_FREQ, 24_000_000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- DIV, CLK_FREQ/(BAUD*16) rounded to nearest (13 at defaults), clocks per oversample tick; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rxd  in  1  serial input from the UART_RXD pad; asynchronous, idles high.
- rx_data  out  8  received byte, valid while rx_valid=1.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts; a transfer happens on a clk edge where rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: the stop bit was sampled low.
- overrun  out  1  one-cycle pulse: a byte completed while the holding register was full and not being read.

Behaviour:
- Reset values:
  - rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0.
  - FSM in IDLE; prescaler=0; tick count=0.
  - Both synchronizer flops=1.
- Synchronizer: rxd passes through 2 flops giving rxd_s. All decisions use rxd_s only.
- Prescaler:
  - Counts 0..DIV-1 and produces tick on DIV-1.
  - Forced to 0 when a start edge is detected.
- FSM states IDLE, START, DATA, STOP, BREAK.
- IDLE: rxd_s is 0 and the previous rxd_s was 1 → START, with prescaler and tick count cleared.
- START: after 8 ticks, sample rxd_s.
  - 0 → DATA, bit index 0.
  - 1 → IDLE (glitch rejected; no outputs change).
- DATA:
  - Every 16 ticks, sample rxd_s and shift it into the shift register LSB-first.
  - After bit 7 → STOP.
- STOP: after 16 ticks, sample rxd_s.
  - 1 → byte complete, then IDLE.
  - 0 → frame_err=1 for one cycle, byte discarded, then BREAK.
- BREAK: wait for rxd_s=1, then IDLE. This guarantees that a held-low line yields exactly one frame_err.
- Byte completion, in the cycle after the stop sample:
  - If rx_valid=0, or rx_valid && rx_ready in the stop-sample cycle: load rx_data and set rx_valid=1.
  - Otherwise: keep the old rx_data and rx_valid=1, drop the new byte, and pulse overrun=1 for one cycle.
- rx_valid clears on a transfer unless a new byte loads on the same edge; a load takes priority and rx_valid stays 1.
- rx_data is stable while rx_valid=1 and is never changed by a rejected byte.
- Latency: rx_valid rises 1 clk after the stop-bit centre sample, which is about 9.5 bit times after the start edge plus 2 synchronizer clks.
- Back-to-back frames: IDLE re-arms immediately after the stop sample. A start edge arriving half a bit later is accepted.
- Tolerance: the combined TX and RX clock error must stay within ±2% for error-free reception.
- Reset mid-frame: the frame is abandoned, everything returns to reset values, and the next complete frame is received correctly.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, STOP, BREAK};
  - localparams OVERSAMPLE=16, DATA_BITS=8.
  - The transmitter shares these constants.
- Sub-module uart_baud_tick contains the prescaler, with ports clk, reset, clear, tick and parameter DIV. The TX side reuses it.

Test Plan:
- Defaults (DIV=13, bit=208 clks), rx_ready=1, send 0x55 → rx_valid pulses once with rx_data=0x55; frame_err=0, overrun=0.
- Glitch: rxd low for 39 clks (3 ticks), then high → no rx_valid, no frame_err, FSM back in IDLE; a following 0xA5 frame is received as 0xA5.
- Frame with stop bit=0, byte 0x3C → frame_err single-cycle pulse, rx_valid stays 0. Line held low for 2 ms → still exactly one pulse.
- rx_ready=0, send 0x12 then 0x34 → rx_data=0x12 with rx_valid=1, one overrun pulse at the end of 0x34. Then set rx_ready=1 → 0x12 consumed and rx_valid=0.
- rx_ready=1, send 0x00, 0xFF, 0x81 back-to-back with no idle gap, at BAUD+2% and again at BAUD-2% → three rx_valid pulses with values in order, no errors.
- Assert reset for 5 clks during data bit 3 of 0x6B → all outputs at reset values. A following 0xC3 frame is received as 0xC3.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// Used by the receiver (uart_rx) and by the transmitter on the UART_TXD side.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: counts 0..DIV-1 and asserts tick while the count is DIV-1.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   clear - forces the count back to 0 (phase alignment to a start edge)
//   tick  - one-cycle oversample strobe, registered
module uart_baud_tick #(
  parameter int unsigned DIV = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_d;

  // Next count; tick is registered so it lines up with cnt_q == DIV-1.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DIV - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d = !clear && (cnt_d == CNT_W'(DIV - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= tick_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, centre-of-bit sampling and a
// one-byte holding register on a valid/ready interface.
// Ports:
//   clk       - system clock
//   reset     - asynchronous, active-high reset
//   rxd       - asynchronous serial input, idles high
//   rx_data   - received byte, valid while rx_valid=1
//   rx_valid  - holding register full
//   rx_ready  - consumer accepts (transfer on rx_valid && rx_ready)
//   frame_err - one-cycle pulse when the stop bit samples low
//   overrun   - one-cycle pulse when a byte is dropped because the holding register is full
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 24_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned DIV      = (CLK_FREQ + BAUD * 8) / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  logic [1:0]           sync_q;
  logic                 rxd_s;
  logic                 rxd_prev;
  logic                 tick;
  logic                 start_edge_c;

  uart_rx_state_t       state, state_d;
  logic [TICK_W-1:0]    tick_cnt, tick_cnt_d;
  logic [BIT_W-1:0]     bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           rx_data_d;
  logic                 rx_valid_d;
  logic                 frame_err_d;
  logic                 overrun_d;

  assign rxd_s = sync_q[1];

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= 2'b11;
      rxd_prev <= 1'b1;
    end else begin
      sync_q   <= {sync_q[0], rxd};
      rxd_prev <= rxd_s;
    end
  end

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clear (start_edge_c),
    .tick  (tick)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state;
    tick_cnt_d   = tick_cnt;
    bit_idx_d    = bit_idx;
    shift_d      = shift_q;
    rx_data_d    = rx_data;
    rx_valid_d   = rx_valid && !rx_ready;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    start_edge_c = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rxd_s && rxd_prev) begin
          start_edge_c = 1'b1;
          tick_cnt_d   = '0;
          state_d      = START;
        end
      end

      // Half a bit in: confirm the start bit is still low.
      START: begin
        if (tick) begin
          if (tick_cnt == TICK_W'(OVERSAMPLE / 2 - 1)) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = rxd_s ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt + TICK_W'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            shift_d    = {rxd_s, shift_q[DATA_BITS-1:1]};
            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
              state_d = STOP;
            end else begin
              bit_idx_d = bit_idx + BIT_W'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt + TICK_W'(1);
          end
        end
      end

      // A read in the same cycle frees the holding register for the new byte.
      STOP: begin
        if (tick) begin
          if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            if (rxd_s) begin
              state_d    = IDLE;
              rx_valid_d = 1'b1;
              if (!rx_valid || rx_ready) begin
                rx_data_d = shift_q;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt + TICK_W'(1);
          end
        end
      end

      // Hold off until the line returns high so a stuck-low line reports once.
      BREAK: begin
        if (rxd_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_d;
      tick_cnt  <= tick_cnt_d;
      bit_idx   <= bit_idx_d;
      shift_q   <= shift_d;
      rx_data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the stimulus pushes expected bytes, a monitor
// pops and compares them on every transfer and counts error pulses.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 208;   // DIV=13 x 16
  localparam int BIT_FAST = 204;   // BAUD +2%
  localparam int BIT_SLOW = 212;   // BAUD -2%

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int checks;
  int errors;
  int valid_cycles;
  int fe_cnt;
  int ov_cnt;
  logic [7:0] sb[$];

  uart_rx #(
    .CLK_FREQ (24_000_000),
    .BAUD     (115200)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples just after the falling edge, ahead of the transfer edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (rx_valid)  valid_cycles++;
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
        if (rx_valid && rx_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_byte", 32'(rx_data), 32'hFFFF_FFFF);
          end else begin
            check("rx_data", 32'(rx_data), 32'(sb.pop_front()));
          end
        end
      end
    end
  end

  // All line driving happens on falling edges.
  task automatic send_byte(input logic [7:0] d, input logic stop, input int bclk);
    rxd = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (bclk) @(negedge clk);
    end
    rxd = stop;
    repeat (bclk) @(negedge clk);
  endtask

  task automatic idle(input int nclk);
    rxd = 1'b1;
    repeat (nclk) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int vc0, fe0, ov0;
    int bclk_tbl[2];
    checks = 0; errors = 0;
    valid_cycles = 0; fe_cnt = 0; ov_cnt = 0;
    rxd = 1'b1; rx_ready = 1'b1; reset = 1'b1;
    bclk_tbl[0] = BIT_FAST;
    bclk_tbl[1] = BIT_SLOW;

    repeat (5) @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    idle(2 * BIT_CLKS);

    // Single byte 0x55
    vc0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
    sb.push_back(8'h55);
    send_byte(8'h55, 1'b1, BIT_CLKS);
    idle(BIT_CLKS);
    wait_drain("drain_55");
    check("valid_once_55", 32'(valid_cycles - vc0), 32'd1);
    check("fe_55", 32'(fe_cnt - fe0), 32'd0);
    check("ov_55", 32'(ov_cnt - ov0), 32'd0);

    // Start-bit glitch of 3 ticks is rejected, then 0xA5
    vc0 = valid_cycles; fe0 = fe_cnt;
    rxd = 1'b0;
    repeat (39) @(negedge clk);
    idle(3 * BIT_CLKS);
    check("glitch_no_valid", 32'(valid_cycles - vc0), 32'd0);
    check("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_idle", 32'(dut.state), 32'(IDLE));
    sb.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, BIT_CLKS);
    idle(BIT_CLKS);
    wait_drain("drain_a5");

    // Bad stop bit, line held low for 2 ms
    vc0 = valid_cycles; fe0 = fe_cnt;
    send_byte(8'h3C, 1'b0, BIT_CLKS);
    check("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
    repeat (48000) @(negedge clk);
    idle(4 * BIT_CLKS);
    check("fe_once_held_low", 32'(fe_cnt - fe0), 32'd1);
    check("fe_no_valid", 32'(valid_cycles - vc0), 32'd0);

    // Overrun: consumer stalled across two bytes
    ov0 = ov_cnt;
    rx_ready = 1'b0;
    sb.push_back(8'h12);
    send_byte(8'h12, 1'b1, BIT_CLKS);
    idle(2 * BIT_CLKS);
    send_byte(8'h34, 1'b1, BIT_CLKS);
    idle(2 * BIT_CLKS);
    check("ov_pulse", 32'(ov_cnt - ov0), 32'd1);
    check("ov_hold_data", 32'(rx_data), 32'h12);
    check("ov_hold_valid", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    wait_drain("drain_12");
    @(negedge clk);
    #2;
    check("ov_valid_cleared", 32'(rx_valid), 32'd0);

    // Back-to-back frames at +2% and -2% bit rate
    foreach (bclk_tbl[k]) begin
      @(negedge clk);
      vc0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
      sb.push_back(8'h00);
      sb.push_back(8'hFF);
      sb.push_back(8'h81);
      send_byte(8'h00, 1'b1, bclk_tbl[k]);
      send_byte(8'hFF, 1'b1, bclk_tbl[k]);
      send_byte(8'h81, 1'b1, bclk_tbl[k]);
      idle(BIT_CLKS);
      wait_drain("drain_b2b");
      check("b2b_valid_cnt", 32'(valid_cycles - vc0), 32'd3);
      check("b2b_fe", 32'(fe_cnt - fe0), 32'd0);
      check("b2b_ov", 32'(ov_cnt - ov0), 32'd0);
    end

    // Reset in the middle of data bit 3 of 0x6B
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd = ((8'h6B >> i) & 8'h01) != 8'h00;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_rx_data", 32'(rx_data), 32'h00);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_frame_err", 32'(frame_err), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    idle(2 * BIT_CLKS);
    fe0 = fe_cnt;
    sb.push_back(8'hC3);
    send_byte(8'hC3, 1'b1, BIT_CLKS);
    idle(BIT_CLKS);
    wait_drain("drain_c3");
    check("c3_fe", 32'(fe_cnt - fe0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
